// File: rtl/brushless_drive_seq_if.sv
// Command, hall-sensor and drive-output bundle for brushless_drive_seq.
// The hall_err signal exists only when HALL_ERR_CHK_EN is defined.
interface brushless_drive_seq_if;
    logic        cmd_en;
    logic [11:0] cmd_mag;
    logic        brake_req;
    logic        hallGrn;
    logic        hallYlw;
    logic        hallBlu;
    logic        PWM_synch;
    logic [11:0] drv_mag;
    logic        brake_n;
    logic        stall;
    logic [2:0]  state;
`ifdef HALL_ERR_CHK_EN
    logic        hall_err;
`endif

    modport master (
        output cmd_en, cmd_mag, brake_req, hallGrn, hallYlw, hallBlu, PWM_synch,
        input  drv_mag, brake_n, stall, state
`ifdef HALL_ERR_CHK_EN
        , input hall_err
`endif
    );

    modport slave (
        input  cmd_en, cmd_mag, brake_req, hallGrn, hallYlw, hallBlu, PWM_synch,
        output drv_mag, brake_n, stall, state
`ifdef HALL_ERR_CHK_EN
        , output hall_err
`endif
    );
endinterface

// File: rtl/brushless_drive_seq.sv
// Drive sequencer ahead of the commutation block: soft ramp, timed brake, stall fault.
// Define HALL_ERR_CHK_EN to also fault on illegal hall codes (000/111) and expose hall_err.
module brushless_drive_seq #(
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned STALL_PER = 64,
    parameter logic [11:0] STALL_MIN = 12'h100,
    parameter int unsigned BRAKE_PER = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    brushless_drive_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        BRAKE = 3'd3,
        STALL = 3'd4
    } state_t;

    localparam int SCW = $clog2(STALL_PER + 1);
    localparam int BCW = $clog2(BRAKE_PER + 1);
    localparam logic [SCW-1:0] STALL_LIM = SCW'(STALL_PER);
    localparam logic [BCW-1:0] BRAKE_LIM = BCW'(BRAKE_PER);
    localparam logic [12:0]    STEP      = 13'(RAMP_STEP);

    logic [2:0]     hall_meta, hall_sync, hall_prev;
    state_t         state_q, state_d;
    logic [11:0]    mag_q, mag_d;
    logic           brake_n_q, brake_n_d;
    logic           stall_q, stall_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic [BCW-1:0] brk_cnt_q, brk_cnt_d;

    logic           hall_chg, driving, armed, stall_hit, fault;
    logic [11:0]    tgt, ramp_mag;
    logic [12:0]    up, dn;

    assign hall_chg  = (hall_sync != hall_prev);
    assign tgt       = bus.cmd_en ? bus.cmd_mag : 12'd0;
    assign driving   = (state_q == RAMP) || (state_q == RUN);
    assign armed     = driving && (mag_q >= STALL_MIN);
    assign stall_hit = armed && (stall_cnt_q == STALL_LIM);

`ifdef HALL_ERR_CHK_EN
    logic hall_bad, hall_err_hit;
    logic bad_seen_q, bad_seen_d;
    logic hall_err_q, hall_err_d;

    assign hall_bad     = (hall_sync == 3'b000) || (hall_sync == 3'b111);
    assign hall_err_hit = driving && bus.PWM_synch && hall_bad && bad_seen_q;
    assign fault        = stall_hit || hall_err_hit;

    // Remembers whether the previous PWM period's sample was already illegal.
    always_comb begin
        bad_seen_d = bad_seen_q;
        if (!driving)
            bad_seen_d = 1'b0;
        else if (bus.PWM_synch)
            bad_seen_d = hall_bad;
    end

    assign bus.hall_err = hall_err_q;
`else
    assign fault = stall_hit;
`endif

    // 13-bit arithmetic so the step can clamp at the target without wrapping.
    always_comb begin
        up       = {1'b0, mag_q} + STEP;
        dn       = {1'b0, mag_q} - STEP;
        ramp_mag = mag_q;
        if (mag_q < tgt)
            ramp_mag = (up > {1'b0, tgt}) ? tgt : up[11:0];
        else if (mag_q > tgt)
            ramp_mag = (dn[12] || (dn < {1'b0, tgt})) ? tgt : dn[11:0];
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!armed || hall_chg)
            stall_cnt_d = '0;
        else if (bus.PWM_synch && (stall_cnt_q != STALL_LIM))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        brake_n_d = 1'b1;
        stall_d   = stall_q;
        brk_cnt_d = brk_cnt_q;
`ifdef HALL_ERR_CHK_EN
        hall_err_d = hall_err_q;
`endif
        case (state_q)
            IDLE: begin
                mag_d = '0;
                if (bus.brake_req) begin
                    state_d   = BRAKE;
                    brake_n_d = 1'b0;
                    brk_cnt_d = '0;
                end else if (bus.cmd_en) begin
                    state_d = RAMP;
                end
            end
            RAMP, RUN: begin
                if (fault) begin
                    state_d   = STALL;
                    mag_d     = '0;
                    brake_n_d = 1'b0;
                    stall_d   = 1'b1;
                    brk_cnt_d = '0;
`ifdef HALL_ERR_CHK_EN
                    hall_err_d = hall_err_hit;
`endif
                end else if (bus.brake_req) begin
                    state_d   = BRAKE;
                    mag_d     = '0;
                    brake_n_d = 1'b0;
                    brk_cnt_d = '0;
                end else if (state_q == RAMP) begin
                    if (bus.PWM_synch)
                        mag_d = ramp_mag;
                    if ((mag_q == tgt) && bus.cmd_en)
                        state_d = RUN;
                    else if ((mag_q == 12'd0) && !bus.cmd_en)
                        state_d = IDLE;
                end else if (tgt != mag_q) begin
                    state_d = RAMP;
                end
            end
            BRAKE, STALL: begin
                mag_d     = '0;
                brake_n_d = 1'b0;
                if (bus.PWM_synch && (brk_cnt_q != BRAKE_LIM))
                    brk_cnt_d = brk_cnt_q + 1'b1;
                if (brk_cnt_q == BRAKE_LIM) begin
                    // Brake exits on request release; a stall only on dropping the run request.
                    if ((state_q == BRAKE) ? !bus.brake_req : !bus.cmd_en) begin
                        state_d   = IDLE;
                        brake_n_d = 1'b1;
                        stall_d   = 1'b0;
`ifdef HALL_ERR_CHK_EN
                        hall_err_d = 1'b0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mag_d   = '0;
                stall_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hall_meta   <= '0;
            hall_sync   <= '0;
            hall_prev   <= '0;
            state_q     <= IDLE;
            mag_q       <= '0;
            brake_n_q   <= 1'b1;
            stall_q     <= 1'b0;
            stall_cnt_q <= '0;
            brk_cnt_q   <= '0;
`ifdef HALL_ERR_CHK_EN
            bad_seen_q  <= 1'b0;
            hall_err_q  <= 1'b0;
`endif
        end else begin
            hall_meta   <= {bus.hallGrn, bus.hallYlw, bus.hallBlu};
            hall_sync   <= hall_meta;
            hall_prev   <= hall_sync;
            state_q     <= state_d;
            mag_q       <= mag_d;
            brake_n_q   <= brake_n_d;
            stall_q     <= stall_d;
            stall_cnt_q <= stall_cnt_d;
            brk_cnt_q   <= brk_cnt_d;
`ifdef HALL_ERR_CHK_EN
            bad_seen_q  <= bad_seen_d;
            hall_err_q  <= hall_err_d;
`endif
        end
    end

    assign bus.drv_mag = mag_q;
    assign bus.brake_n = brake_n_q;
    assign bus.stall   = stall_q;
    assign bus.state   = state_q;
endmodule
